fastram_term: RTL and testbench

FASTRAM_TERM -- requirements
Module: fastram_term

---
 rtl/fastram_if.sv | 22 ++
 rtl/fastram_term.sv | 110 +++++++++++
 tb/tb_fastram_term.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/fastram_if.sv
// CPU-side bus between the 68030 and the fast-RAM termination block.
interface fastram_if;
    logic       AS20;
    logic       RW20;
    logic       RAMSEL;
    logic [1:0] A;
    logic       CBREQ;
    logic       STERM;
    logic       CBACK;
    logic [1:0] BA;
    logic       BUSY;

    modport master (
        output AS20, RW20, RAMSEL, A, CBREQ,
        input  STERM, CBACK, BA, BUSY
    );

    modport slave (
        input  AS20, RW20, RAMSEL, A, CBREQ,
        output STERM, CBACK, BA, BUSY
    );
endinterface

// File: rtl/fastram_term.sv
// Synchronous termination (STERM) and cache-burst sequencing for 68030 fast-RAM accesses.
module fastram_term #(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    fastram_if.slave   bus
);
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned BEAT_W = 2;
    localparam logic [CNT_W-1:0]  WS        = CNT_W'(WAIT_STATES);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(3);

    typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [BEAT_W-1:0]  beat;
    logic               burst;

    // Single-process sequencer; every output is a register updated with the state.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            cnt       <= '0;
            beat      <= '0;
            burst     <= 1'b0;
            bus.STERM <= 1'b1;
            bus.CBACK <= 1'b1;
            bus.BA    <= '0;
            bus.BUSY  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.AS20 && !bus.RAMSEL) begin
                        bus.BA    <= bus.A;
                        burst     <= !bus.CBREQ && bus.RW20;
                        bus.CBACK <= !(!bus.CBREQ && bus.RW20);
                        beat      <= '0;
                        cnt       <= WS;
                        bus.BUSY  <= 1'b1;
                        if (WS == '0) begin
                            state     <= ACK;
                            bus.STERM <= 1'b0;
                        end else begin
                            state     <= WAIT;
                        end
                    end
                end

                WAIT: begin
                    if (bus.AS20) begin
                        state     <= IDLE;
                        bus.STERM <= 1'b1;
                        bus.CBACK <= 1'b1;
                        bus.BUSY  <= 1'b0;
                    end else if (cnt == CNT_W'(1)) begin
                        cnt       <= '0;
                        state     <= ACK;
                        bus.STERM <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                ACK: begin
                    if (bus.AS20) begin
                        state     <= IDLE;
                        bus.STERM <= 1'b1;
                        bus.CBACK <= 1'b1;
                        bus.BUSY  <= 1'b0;
                    end else if (burst && beat != LAST_BEAT) begin
                        // Next beat of the line; CBACK rises as the final beat starts.
                        beat   <= beat + BEAT_W'(1);
                        bus.BA <= bus.BA + 2'(1);
                        cnt    <= WS;
                        if (beat == BEAT_W'(2)) begin
                            bus.CBACK <= 1'b1;
                        end
                        if (WS == '0) begin
                            state     <= ACK;
                            bus.STERM <= 1'b0;
                        end else begin
                            state     <= WAIT;
                            bus.STERM <= 1'b1;
                        end
                    end else begin
                        state     <= HOLD;
                        bus.STERM <= 1'b1;
                        bus.CBACK <= 1'b1;
                    end
                end

                HOLD: begin
                    if (bus.AS20) begin
                        state    <= IDLE;
                        bus.BUSY <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    bus.STERM <= 1'b1;
                    bus.CBACK <= 1'b1;
                    bus.BUSY  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fastram_term.sv
// Directed bench: four instances (WAIT_STATES 0..3) share one stimulus stream.
module tb_fastram_term;
    logic       CLK;
    logic       RESET;
    logic       as20;
    logic       rw20;
    logic       ramsel;
    logic [1:0] a;
    logic       cbreq;

    logic [3:0] sterm_v;
    logic [3:0] cback_v;
    logic [3:0] busy_v;
    logic [1:0] ba_v [4];

    int n_chk  = 0;
    int n_fail = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        fastram_if bus ();
        assign bus.AS20   = as20;
        assign bus.RW20   = rw20;
        assign bus.RAMSEL = ramsel;
        assign bus.A      = a;
        assign bus.CBREQ  = cbreq;
        fastram_term #(.WAIT_STATES(g)) u_dut (
            .CLK   (CLK),
            .RESET (RESET),
            .bus   (bus)
        );
        assign sterm_v[g] = bus.STERM;
        assign cback_v[g] = bus.CBACK;
        assign busy_v[g]  = bus.BUSY;
        assign ba_v[g]    = bus.BA;
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Compare all four outputs of the instance with the given wait-state count.
    task automatic check_dut(input string tag, input int w, input logic st, input logic cb,
                             input logic [1:0] ba, input logic bz);
        check($sformatf("%s ws%0d STERM", tag, w), 8'(sterm_v[w]), 8'(st));
        check($sformatf("%s ws%0d CBACK", tag, w), 8'(cback_v[w]), 8'(cb));
        check($sformatf("%s ws%0d BA", tag, w),    8'(ba_v[w]),    8'(ba));
        check($sformatf("%s ws%0d BUSY", tag, w),  8'(busy_v[w]),  8'(bz));
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int L;
        RESET  = 1'b0;
        as20   = 1'b1;
        ramsel = 1'b1;
        rw20   = 1'b1;
        cbreq  = 1'b1;
        a      = 2'd0;
        tick();
        for (int w = 0; w < 4; w++) check_dut("reset", w, 1'b1, 1'b1, 2'd0, 1'b0);
        tick();
        RESET = 1'b1;
        tick();
        for (int w = 0; w < 4; w++) check_dut("idle", w, 1'b1, 1'b1, 2'd0, 1'b0);

        // Non-burst read, A=2; RAMSEL toggles after start and in HOLD.
        a = 2'd2; rw20 = 1'b1; cbreq = 1'b1; as20 = 1'b0; ramsel = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            ramsel = (k % 2 == 0);
            for (int w = 0; w < 4; w++)
                check_dut($sformatf("single k%0d", k), w, (k == w) ? 1'b0 : 1'b1, 1'b1, 2'd2, 1'b1);
        end
        as20 = 1'b1; ramsel = 1'b1;
        tick();
        for (int w = 0; w < 4; w++) check_dut("single end", w, 1'b1, 1'b1, 2'd2, 1'b0);

        // Burst read from A=3; CBREQ release after start is ignored.
        a = 2'd3; rw20 = 1'b1; cbreq = 1'b0; as20 = 1'b0; ramsel = 1'b0;
        for (int k = 0; k < 17; k++) begin
            tick();
            if (k == 0) begin
                cbreq  = 1'b1;
                ramsel = 1'b1;
            end
            for (int w = 0; w < 4; w++) begin
                L = w + 1;
                if (k < 4 * L)
                    check_dut($sformatf("burst k%0d", k), w,
                              (k % L == w) ? 1'b0 : 1'b1,
                              (k < 3 * L) ? 1'b0 : 1'b1,
                              2'((3 + k / L) % 4), 1'b1);
                else
                    check_dut($sformatf("burst k%0d", k), w, 1'b1, 1'b1, 2'd2, 1'b1);
            end
        end
        as20 = 1'b1;
        tick();
        for (int w = 0; w < 4; w++) check_dut("burst end", w, 1'b1, 1'b1, 2'd2, 1'b0);

        // Write with CBREQ low never bursts.
        a = 2'd1; rw20 = 1'b0; cbreq = 1'b0; as20 = 1'b0; ramsel = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 0) ramsel = 1'b1;
            for (int w = 0; w < 4; w++)
                check_dut($sformatf("write k%0d", k), w, (k == w) ? 1'b0 : 1'b1, 1'b1, 2'd1, 1'b1);
        end
        as20 = 1'b1;
        tick();

        // AS20 alone without RAMSEL starts nothing.
        as20 = 1'b0; ramsel = 1'b1; rw20 = 1'b1; cbreq = 1'b1; a = 2'd2;
        tick();
        tick();
        for (int w = 0; w < 4; w++) check_dut("no sel", w, 1'b1, 1'b1, 2'd1, 1'b0);

        // Abort from WAIT/ACK by raising AS20.
        ramsel = 1'b0;
        tick();
        check_dut("abort start", 3, 1'b1, 1'b1, 2'd2, 1'b1);
        check_dut("abort start", 0, 1'b0, 1'b1, 2'd2, 1'b1);
        as20 = 1'b1;
        tick();
        for (int w = 0; w < 4; w++) check_dut("abort", w, 1'b1, 1'b1, 2'd2, 1'b0);
        tick();
        check_dut("abort after", 3, 1'b1, 1'b1, 2'd2, 1'b0);

        // Reset during the second burst beat, then a fresh access.
        a = 2'd0; rw20 = 1'b1; cbreq = 1'b0; as20 = 1'b0; ramsel = 1'b0;
        repeat (4) tick();
        check_dut("pre-reset", 1, 1'b0, 1'b0, 2'd1, 1'b1);
        #1 RESET = 1'b0;
        #1;
        for (int w = 0; w < 4; w++) check_dut("async reset", w, 1'b1, 1'b1, 2'd0, 1'b0);
        cbreq = 1'b1; a = 2'd2;
        #1 RESET = 1'b1;
        tick();
        check_dut("post-reset k0", 1, 1'b1, 1'b1, 2'd2, 1'b1);
        check_dut("post-reset k0", 0, 1'b0, 1'b1, 2'd2, 1'b1);
        tick();
        check_dut("post-reset k1", 1, 1'b0, 1'b1, 2'd2, 1'b1);
        tick();
        check_dut("post-reset k2", 1, 1'b1, 1'b1, 2'd2, 1'b1);
        as20 = 1'b1;
        tick();
        for (int w = 0; w < 4; w++) check_dut("post-reset end", w, 1'b1, 1'b1, 2'd2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
